// File: rtl/wb_arbiter_2to1.sv
// Two-master, one-slave Wishbone B4 classic arbiter.
// Round-robin grant held for the whole cycle, with an optional hang watchdog.
module wb_arbiter_2to1 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i
);

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int WDW =
    WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX =
    WDW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           lg_q;
  logic [WDW-1:0] wd_q;
  logic [WDW-1:0] wd_d;

  logic        g_cyc;
  logic        g_stb;
  logic        g_we;
  logic [31:0] g_adr;
  logic [3:0]  g_sel;
  logic [31:0] g_dat;
  logic        term;
  logic        wd_fire;
  logic        gnt0;
  logic        gnt1;

  // Round-robin pick: on contention the master that was not last granted wins.
  function automatic state_t arb(
    input logic c0,
    input logic c1,
    input logic lg
  );
    state_t r;
    r = IDLE;
    if (c0 && c1) r = lg ? GNT0 : GNT1;
    else if (c0)  r = GNT0;
    else if (c1)  r = GNT1;
    return r;
  endfunction

  // Next-state: hold grant while owner keeps cyc, otherwise re-arbitrate.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = arb(m0_cyc_i, m1_cyc_i, lg_q);
      GNT0:    if (!m0_cyc_i)
                 state_d = arb(m0_cyc_i, m1_cyc_i, lg_q);
      GNT1:    if (!m1_cyc_i)
                 state_d = arb(m0_cyc_i, m1_cyc_i, lg_q);
      default: state_d = IDLE;
    endcase
  end

  // State, last-grant and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lg_q    <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (state_d == GNT0 && state_q != GNT0)
        lg_q <= 1'b0;
      else if (state_d == GNT1 && state_q != GNT1)
        lg_q <= 1'b1;
    end
  end

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Select the granted master's request bundle; zeros when idle.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_sel = '0;
    g_dat = '0;
    unique case (1'b1)
      gnt0: begin
        g_cyc = m0_cyc_i;
        g_stb = m0_stb_i;
        g_we  = m0_we_i;
        g_adr = m0_adr_i;
        g_sel = m0_sel_i;
        g_dat = m0_dat_i;
      end
      gnt1: begin
        g_cyc = m1_cyc_i;
        g_stb = m1_stb_i;
        g_we  = m1_we_i;
        g_adr = m1_adr_i;
        g_sel = m1_sel_i;
        g_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign term = s_ack_i | s_err_i | s_rty_i;

  // A real slave termination always beats a forced error.
  assign wd_fire = WD_EN && g_cyc && g_stb &&
                   !term && (wd_q == WD_MAX);

  // Watchdog count: runs only while a strobe waits unanswered.
  always_comb begin
    wd_d = wd_q;
    if (!WD_EN || state_q == IDLE ||
        state_d != state_q || term || wd_fire)
      wd_d = '0;
    else if (g_cyc && g_stb)
      wd_d = wd_q + WDW'(1);
  end

  assign s_cyc_o = g_cyc;
  assign s_stb_o = g_stb & ~wd_fire;
  assign s_we_o  = g_we;
  assign s_adr_o = g_adr;
  assign s_sel_o = g_sel;
  assign s_dat_o = g_dat;

  assign m0_dat_o = gnt0 ? s_dat_i : '0;
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m0_err_o = gnt0 & (s_err_i | wd_fire);
  assign m0_rty_o = gnt0 & s_rty_i;

  assign m1_dat_o = gnt1 ? s_dat_i : '0;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m1_err_o = gnt1 & (s_err_i | wd_fire);
  assign m1_rty_o = gnt1 & s_rty_i;

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1.
// Watchdog limit set to 4 so hang cases stay short.
module tb_wb_arbiter_2to1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic [3:0]  m0_sel_i = '0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 0, s_err_i = 0, s_rty_i = 0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter_2to1 #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_all();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    s_dat_i = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_i = 1; tick(); tick(); rst_i = 0; #1;
    n_total++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000)
      $display("FAIL reset_s_ctl got %b want 000",
               {s_cyc_o, s_stb_o, s_we_o});
    else n_pass++;
    n_total++;
    if (s_adr_o !== 32'h0)
      $display("FAIL reset_s_adr got %h want 0", s_adr_o);
    else n_pass++;
    n_total++;
    if ({m0_ack_o, m0_err_o, m0_rty_o,
         m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0)
      $display("FAIL reset_terms got %b want 000000",
               {m0_ack_o, m0_err_o, m0_rty_o,
                m1_ack_o, m1_err_o, m1_rty_o});
    else n_pass++;
    s_dat_i = 32'h5A5A5A5A; #1;
    n_total++;
    if ({m0_dat_o, m1_dat_o} !== 64'h0)
      $display("FAIL reset_dat got %h/%h want 0/0",
               m0_dat_o, m1_dat_o);
    else n_pass++;
    s_dat_i = '0;
  endtask

  task automatic test_single_read();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
    m0_adr_i = 32'h10; m0_sel_i = 4'hF; #1;
    n_total++;
    if (s_cyc_o !== 1'b0)
      $display("FAIL read_dead_cycle s_cyc got %b want 0", s_cyc_o);
    else n_pass++;
    tick();
    n_total++;
    if ({s_cyc_o, s_stb_o, s_adr_o, m0_ack_o} !== {2'b11, 32'h10, 1'b0})
      $display("FAIL read_grant got cyc%b stb%b adr%h ack%b want 1 1 10 0",
               s_cyc_o, s_stb_o, s_adr_o, m0_ack_o);
    else n_pass++;
    tick();
    s_ack_i = 1; s_dat_i = 32'hDEADBEEF; #1;
    n_total++;
    if ({m0_ack_o, m0_dat_o} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL read_data got ack%b dat%h want 1 deadbeef",
               m0_ack_o, m0_dat_o);
    else n_pass++;
    n_total++;
    if ({m1_ack_o, m1_dat_o} !== 33'h0)
      $display("FAIL read_m1_quiet got ack%b dat%h want 0 0",
               m1_ack_o, m1_dat_o);
    else n_pass++;
    tick();
    idle_all();
    tick();
    n_total++;
    if (s_cyc_o !== 1'b0)
      $display("FAIL read_release s_cyc got %b want 0", s_cyc_o);
    else n_pass++;
  endtask

  task automatic test_rr_repeat();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
    tick();
    n_total++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h200})
      $display("FAIL rr_m1_first got cyc%b adr%h want 1 200",
               s_cyc_o, s_adr_o);
    else n_pass++;
    s_ack_i = 1; #1;
    n_total++;
    if ({m1_ack_o, m0_ack_o} !== 2'b10)
      $display("FAIL rr_ack_route got m1%b m0%b want 1 0",
               m1_ack_o, m0_ack_o);
    else n_pass++;
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_contention();
    rst_i = 1; tick(); rst_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
    tick();
    n_total++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h100})
      $display("FAIL cont_m0_first got cyc%b adr%h want 1 100",
               s_cyc_o, s_adr_o);
    else n_pass++;
    s_ack_i = 1; #1;
    n_total++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10)
      $display("FAIL cont_ack_m0 got m0%b m1%b want 1 0",
               m0_ack_o, m1_ack_o);
    else n_pass++;
    tick();
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    tick();
    n_total++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h200})
      $display("FAIL cont_handoff got cyc%b adr%h want 1 200",
               s_cyc_o, s_adr_o);
    else n_pass++;
    s_ack_i = 1; #1;
    n_total++;
    if ({m1_ack_o, m0_ack_o} !== 2'b10)
      $display("FAIL cont_ack_m1 got m1%b m0%b want 1 0",
               m1_ack_o, m0_ack_o);
    else n_pass++;
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_burst();
    logic [31:0] a;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h40;
    tick();
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h300;
    for (int i = 0; i < 4; i++) begin
      a = 32'h40 + 32'(4 * i);
      m0_adr_i = a; s_ack_i = 1; #1;
      n_total++;
      if ({s_adr_o, m0_ack_o, m1_ack_o} !== {a, 2'b10})
        $display("FAIL burst_beat%0d got adr%h m0%b m1%b want %h 1 0",
                 i, s_adr_o, m0_ack_o, m1_ack_o, a);
      else n_pass++;
      tick();
    end
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    tick();
    n_total++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h300})
      $display("FAIL burst_m1_after got cyc%b adr%h want 1 300",
               s_cyc_o, s_adr_o);
    else n_pass++;
    s_ack_i = 1;
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_timeout();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF;
    m1_adr_i = 32'h20; m1_dat_i = 32'h12345678;
    tick();
    n_total++;
    if ({s_we_o, s_adr_o, s_dat_o} !== {1'b1, 32'h20, 32'h12345678})
      $display("FAIL wd_write_path got we%b adr%h dat%h want 1 20 12345678",
               s_we_o, s_adr_o, s_dat_o);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) begin
        n_total++;
        if ({m1_err_o, s_stb_o} !== 2'b01)
          $display("FAIL wd_wait%0d got err%b stb%b want 0 1",
                   k, m1_err_o, s_stb_o);
        else n_pass++;
      end else begin
        n_total++;
        if ({m1_err_o, m1_ack_o, s_stb_o, s_cyc_o} !== 4'b1001)
          $display("FAIL wd_fire got err%b ack%b stb%b cyc%b want 1 0 0 1",
                   m1_err_o, m1_ack_o, s_stb_o, s_cyc_o);
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if ({m1_err_o, s_stb_o} !== 2'b01)
      $display("FAIL wd_restart got err%b stb%b want 0 1",
               m1_err_o, s_stb_o);
    else n_pass++;
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_ack_at_limit();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h24;
    tick();
    for (int k = 0; k < 4; k++) tick();
    s_ack_i = 1; #1;
    n_total++;
    if ({m1_ack_o, m1_err_o, s_stb_o} !== 3'b101)
      $display("FAIL wd_ack_prio got ack%b err%b stb%b want 1 0 1",
               m1_ack_o, m1_err_o, s_stb_o);
    else n_pass++;
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h500;
    tick();
    n_total++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h500})
      $display("FAIL rstmid_grant got cyc%b adr%h want 1 500",
               s_cyc_o, s_adr_o);
    else n_pass++;
    rst_i = 1; tick(); rst_i = 0;
    s_ack_i = 1; s_err_i = 1; s_rty_i = 1; s_dat_i = 32'hCAFEF00D; #1;
    n_total++;
    if ({s_cyc_o, m1_ack_o, m1_err_o, m1_rty_o} !== 4'b0000)
      $display("FAIL rstmid_abandon got cyc%b ack%b err%b rty%b want 0 0 0 0",
               s_cyc_o, m1_ack_o, m1_err_o, m1_rty_o);
    else n_pass++;
    n_total++;
    if (m1_dat_o !== 32'h0)
      $display("FAIL rstmid_dat got %h want 0", m1_dat_o);
    else n_pass++;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h600;
    tick();
    n_total++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h600})
      $display("FAIL rstmid_m0_first got cyc%b adr%h want 1 600",
               s_cyc_o, s_adr_o);
    else n_pass++;
    idle_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_repeat();
    test_contention();
    test_burst();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
